chip8_pixel_gen: RTL and testbench

- Upstream neighbour of the VGA timing driver in the CHIP-8 display path.
- Converts the driver's pixel coordinates into RGB565 `pixel_data`.
- Source image is the 64x32 monochrome CHIP-8 framebuffer (256 bytes), scaled 10x to 640x320 and centred vertically in the 480-line frame, with border colour above and below.
- Prefetches one CHIP-8 row (8 bytes) per row boundary into a 64-bit line buffer over a req/gnt/valid read port during horizontal/vertical blanking.

---
 rtl/chip8_video_pkg.sv | 12 +
 rtl/chip8_row_fetch.sv | 46 ++++
 rtl/chip8_pixel_gen.sv | 95 +++++++++
 tb/tb_chip8_pixel_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_video_pkg.sv
// chip8_video_pkg: shared CHIP-8 display geometry, RGB565 colours and row-fetch FSM states
package chip8_video_pkg;
  localparam int CHIP8_W = 64;
  localparam int CHIP8_H = 32;
  localparam int FB_BYTES = 256;
  localparam int H_DISP = 640;
  localparam int V_DISP = 480;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_NAVY = 16'h0010;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/chip8_row_fetch.sv
// chip8_row_fetch: reads one 8-byte CHIP-8 row over req/gnt/valid into a 64-bit line buffer
module chip8_row_fetch
  import chip8_video_pkg::*;
(
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  chip_row,
  output logic        fb_rd_req,
  output logic [7:0]  fb_rd_addr,
  input  logic        fb_rd_gnt,
  input  logic        fb_rd_valid,
  input  logic [7:0]  fb_rd_data,
  output logic [63:0] line_buf,
  output logic        busy
);
  fetch_state_e state;
  logic [4:0] row_q;
  logic [2:0] byte_idx;
  assign fb_rd_req = state == REQ;
  assign fb_rd_addr = {row_q, byte_idx};
  assign busy = state != IDLE;
  always_ff @(posedge clk_25MHz or negedge rst)
    if (!rst) begin
      state <= IDLE;
      row_q <= '0;
      byte_idx <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          row_q <= chip_row;
          byte_idx <= '0;
        end
        REQ: if (fb_rd_gnt) state <= WAIT;
        WAIT: if (fb_rd_valid) begin
          // byte 0 lands in the top byte so bit 63 is the leftmost pixel
          line_buf[{~byte_idx, 3'b000} +: 8] <= fb_rd_data;
          state <= (byte_idx == 3'd7) ? IDLE : REQ;
          byte_idx <= (byte_idx == 3'd7) ? byte_idx : byte_idx + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/chip8_pixel_gen.sv
// chip8_pixel_gen: turns VGA pixel coordinates into RGB565 from a 10x scaled 64x32 CHIP-8 image
module chip8_pixel_gen
  import chip8_video_pkg::*;
#(
  parameter int          SCALE        = 10,
  parameter int          V_OFFSET     = 80,
  parameter logic [15:0] FG_COLOR     = RGB_WHITE,
  parameter logic [15:0] BG_COLOR     = RGB_BLACK,
  parameter logic [15:0] BORDER_COLOR = RGB_NAVY
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [9:0]  pixel_hpos,
  input  logic        vga_vs,
  output logic [15:0] pixel_data,
  output logic        fb_rd_req,
  output logic [7:0]  fb_rd_addr,
  input  logic        fb_rd_gnt,
  input  logic        fb_rd_valid,
  input  logic [7:0]  fb_rd_data,
  output logic        underrun
);
  localparam int SW = $clog2(SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  logic vs_q, end_q, in_img, busy, line_end, first_px, start;
  logic [8:0] line_idx;
  logic [SW-1:0] sub_row, nx_sub, cur_sub;
  logic [4:0] chip_row;
  logic [5:0] nx_x, cur_x;
  logic [63:0] line_buf;
  assign line_end = pixel_hpos == 10'(H_DISP);
  assign first_px = pixel_hpos == 10'd1;
  assign start = ((vga_vs & ~vs_q) | end_q) & in_img & (sub_row == '0);
  assign cur_sub = first_px ? '0 : nx_sub;
  assign cur_x = first_px ? '0 : nx_x;
  chip8_row_fetch u_fetch (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .start       (start),
    .chip_row    (chip_row),
    .fb_rd_req   (fb_rd_req),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_gnt   (fb_rd_gnt),
    .fb_rd_valid (fb_rd_valid),
    .fb_rd_data  (fb_rd_data),
    .line_buf    (line_buf),
    .busy        (busy)
  );
  // line_idx, in_img, sub_row and chip_row always describe the next line to be shown
  always_ff @(posedge clk_25MHz or negedge rst)
    if (!rst) begin
      vs_q <= 1'b0;
      end_q <= 1'b0;
      line_idx <= '0;
      in_img <= 1'b0;
      sub_row <= '0;
      chip_row <= '0;
    end else begin
      vs_q <= vga_vs;
      end_q <= line_end;
      if (!vga_vs) begin
        line_idx <= '0;
        in_img <= V_OFFSET == 0;
        sub_row <= '0;
        chip_row <= '0;
      end else if (line_end && line_idx != 9'(V_DISP - 1)) begin
        line_idx <= line_idx + 9'd1;
        if (line_idx + 9'd1 == 9'(V_OFFSET)) begin
          in_img <= 1'b1;
          sub_row <= '0;
          chip_row <= '0;
        end else if (in_img) begin
          sub_row <= (sub_row == SUB_LAST) ? '0 : sub_row + SW'(1);
          if (sub_row == SUB_LAST) begin
            chip_row <= chip_row + 5'd1;
            in_img <= chip_row != 5'(CHIP8_H - 1);
          end
        end
      end
    end
  always_ff @(posedge clk_25MHz or negedge rst)
    if (!rst) begin
      pixel_data <= '0;
      nx_sub <= '0;
      nx_x <= '0;
      underrun <= 1'b0;
    end else begin
      pixel_data <= (pixel_hpos == '0) ? '0 : !in_img ? BORDER_COLOR : line_buf[~cur_x] ? FG_COLOR : BG_COLOR;
      if (pixel_hpos != '0) begin
        nx_sub <= (cur_sub == SUB_LAST) ? '0 : cur_sub + SW'(1);
        nx_x <= (cur_sub == SUB_LAST) ? cur_x + 6'd1 : cur_x;
      end
      underrun <= underrun | (first_px & busy);
    end
endmodule

// File: tb/tb_chip8_pixel_gen.sv
// tb_chip8_pixel_gen: directed VGA frames checked against a behavioural CHIP-8 display model
module tb_chip8_pixel_gen;
  logic clk_25MHz = 1'b0;
  logic rst = 1'b0;
  logic vga_vs = 1'b0;
  logic [9:0] pixel_hpos = '0;
  logic [15:0] pixel_data;
  logic fb_rd_req, underrun;
  logic fb_rd_gnt = 1'b0;
  logic fb_rd_valid = 1'b0;
  logic [7:0] fb_rd_addr;
  logic [7:0] fb_rd_data = '0;

  chip8_pixel_gen dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .pixel_hpos  (pixel_hpos),
    .vga_vs      (vga_vs),
    .pixel_data  (pixel_data),
    .fb_rd_req   (fb_rd_req),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_gnt   (fb_rd_gnt),
    .fb_rd_valid (fb_rd_valid),
    .fb_rd_data  (fb_rd_data),
    .underrun    (underrun)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int total = 0;
  int bad = 0;
  logic [7:0] fb [256];
  bit full_line [480];
  logic [15:0] lit [int];
  int cur_line = -1;
  bit chk_en = 0;
  bit check_px = 1;
  bit un_watch = 0;
  bit gnt_tie = 0;
  int val_delay = 0;
  int grant_line [$];
  logic [7:0] grant_addr [$];
  int n_valid = 0;
  int req_lo = 0;
  int req_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s line=%0d: got %h want %h", name, cur_line, act, exp);
    end
  endtask

  // what the screen must show at line l, column h-1, straight from the framebuffer
  function automatic logic [15:0] model_px(input int l, input int h);
    int x;
    if (h == 0) return 16'h0000;
    if (l < 80 || l >= 400) return 16'h0010;
    x = (h - 1) / 10;
    return fb[((l - 80) / 10) * 8 + x / 8][7 - x % 8] ? 16'hFFFF : 16'h0000;
  endfunction

  initial forever begin : cmp
    int l, h;
    bit en, uw;
    @(posedge clk_25MHz);
    l = cur_line;
    h = int'(pixel_hpos);
    en = chk_en;
    uw = un_watch;
    #1;
    if (en) begin
      check("pixel", {16'h0, pixel_data}, {16'h0, model_px(l, h)});
      if (lit.exists(l * 1024 + h)) check("pixel_lit", {16'h0, pixel_data}, {16'h0, lit[l * 1024 + h]});
    end
    if (uw && l == 80 && h == 1) check("underrun_rise", {31'h0, underrun}, 32'd1);
  end

  initial forever begin : req_mon
    @(posedge clk_25MHz);
    if (fb_rd_req === 1'b1) begin
      if (cur_line < 79) req_lo++;
      if (cur_line >= 399) req_hi++;
    end
  end

  initial begin : responder
    bit pend;
    int cnt;
    logic [7:0] a;
    pend = 0;
    cnt = 0;
    a = '0;
    forever begin
      @(negedge clk_25MHz);
      fb_rd_valid = 1'b0;
      if (pend && cnt == 0) begin
        fb_rd_valid = 1'b1;
        fb_rd_data = fb[a];
        pend = 0;
        n_valid++;
      end else if (pend) cnt--;
      fb_rd_gnt = gnt_tie || (fb_rd_req && !pend);
      if (fb_rd_req && fb_rd_gnt && !pend) begin
        pend = 1;
        cnt = val_delay;
        a = fb_rd_addr;
        grant_line.push_back(cur_line);
        grant_addr.push_back(fb_rd_addr);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic [9:0] h);
    pixel_hpos = h;
    @(negedge clk_25MHz);
  endtask

  task automatic do_vsync();
    cur_line = -1;
    chk_en = 0;
    vga_vs = 1'b0;
    repeat (8) cyc(10'd0);
    vga_vs = 1'b1;
    repeat (4) cyc(10'd0);
  endtask

  task automatic do_line(input int l);
    cur_line = l;
    chk_en = check_px && full_line[l];
    if (full_line[l]) begin
      for (int h = 1; h <= 640; h++) cyc(10'(h));
      repeat (160) cyc(10'd0);
    end else begin
      cyc(10'd640);
      repeat (40) cyc(10'd0);
    end
  endtask

  task automatic clear_stats();
    grant_line.delete();
    grant_addr.delete();
    n_valid = 0;
    req_lo = 0;
    req_hi = 0;
  endtask

  initial begin
    int n;
    logic [7:0] row1 [8];
    row1 = '{8'hF0, 8'h0F, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h81, 8'h3C};
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) fb[i] = 8'h00;
    fb[0] = 8'h80;
    fb[7] = 8'h01;
    for (int i = 0; i < 8; i++) fb[8 + i] = row1[i];
    for (int l = 0; l < 480; l++) full_line[l] = (l == 0) || (l >= 79 && l <= 101) || l == 389 || l == 399 || l == 400 || l == 479;
    for (int h = 1; h <= 10; h++) lit[80 * 1024 + h] = 16'hFFFF;
    for (int h = 631; h <= 640; h++) lit[80 * 1024 + h] = 16'hFFFF;
    lit[80 * 1024 + 11] = 16'h0000;
    lit[80 * 1024 + 630] = 16'h0000;
    lit[89 * 1024 + 1] = 16'hFFFF;
    lit[90 * 1024 + 40] = 16'hFFFF;
    lit[90 * 1024 + 41] = 16'h0000;
    lit[90 * 1024 + 120] = 16'h0000;
    lit[90 * 1024 + 121] = 16'hFFFF;
    lit[0 * 1024 + 1] = 16'h0010;
    lit[79 * 1024 + 640] = 16'h0010;
    lit[400 * 1024 + 1] = 16'h0010;
    lit[479 * 1024 + 640] = 16'h0010;

    @(negedge clk_25MHz);
    check("rst_pixel", {16'h0, pixel_data}, 32'd0);
    check("rst_req", {31'h0, fb_rd_req}, 32'd0);
    check("rst_addr", {24'h0, fb_rd_addr}, 32'd0);
    check("rst_underrun", {31'h0, underrun}, 32'd0);
    repeat (2) @(negedge clk_25MHz);
    rst = 1'b1;
    @(negedge clk_25MHz);

    clear_stats();
    do_vsync();
    for (int l = 0; l < 480; l++) do_line(l);
    chk_en = 0;
    n = 0;
    foreach (grant_line[i])
      if (grant_line[i] >= 80 && grant_line[i] <= 89) begin
        check("row1_addr", {24'h0, grant_addr[i]}, 32'(8 + n));
        check("row1_line", grant_line[i], 32'd89);
        n++;
      end
    check("grants_80_89", n, 32'd8);
    check("grants_frame", grant_line.size(), 32'd256);
    check("valids_frame", n_valid, 32'd256);
    check("req_before_80", req_lo, 32'd0);
    check("req_after_399", req_hi, 32'd0);
    check("no_underrun", {31'h0, underrun}, 32'd0);

    gnt_tie = 1;
    val_delay = 0;
    do_vsync();
    for (int l = 0; l < 89; l++) do_line(l);
    cur_line = 89;
    chk_en = 1;
    for (int h = 1; h <= 640; h++) cyc(10'(h));
    repeat (3) cyc(10'd0);
    chk_en = 0;
    check("req_pre_reset", {31'h0, fb_rd_req}, 32'd1);
    check("addr_pre_reset", {24'h0, fb_rd_addr}, 32'd9);
    #5 rst = 1'b0;
    #1;
    check("mid_rst_pixel", {16'h0, pixel_data}, 32'd0);
    check("mid_rst_req", {31'h0, fb_rd_req}, 32'd0);
    check("mid_rst_addr", {24'h0, fb_rd_addr}, 32'd0);
    check("mid_rst_underrun", {31'h0, underrun}, 32'd0);
    repeat (3) @(negedge clk_25MHz);
    check("held_rst_req", {31'h0, fb_rd_req}, 32'd0);
    check("held_rst_addr", {24'h0, fb_rd_addr}, 32'd0);
    #5 rst = 1'b1;
    @(negedge clk_25MHz);
    clear_stats();
    do_vsync();
    for (int l = 0; l <= 80; l++) do_line(l);
    chk_en = 0;
    check("post_rst_req_before_80", req_lo, 32'd0);
    check("post_rst_grants", grant_line.size(), 32'd8);
    foreach (grant_line[i]) begin
      check("post_rst_addr", {24'h0, grant_addr[i]}, 32'(i));
      check("post_rst_line", grant_line[i], 32'd79);
    end

    gnt_tie = 0;
    val_delay = 30;
    clear_stats();
    do_vsync();
    for (int l = 0; l <= 79; l++) do_line(l);
    check("underrun_before", {31'h0, underrun}, 32'd0);
    un_watch = 1;
    check_px = 0;
    do_line(80);
    do_line(81);
    un_watch = 0;
    chk_en = 0;
    check("underrun_sticky", {31'h0, underrun}, 32'd1);
    check("slow_grants", grant_line.size(), 32'd8);
    check("slow_valids", n_valid, 32'd8);
    foreach (grant_addr[i]) check("slow_addr", {24'h0, grant_addr[i]}, 32'(i));
    repeat (5) cyc(10'd0);
    check("underrun_still", {31'h0, underrun}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
